// File: rtl/regfile_mp_if.sv
// Bus bundle between the core pipeline and the multi-port register file.
// Ports are flat vectors, port i occupying slice [i*W +: W].
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] RdAddr;
  logic [NUM_RD*DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]        RdBusy;
  logic [NUM_WR-1:0]        WrEn;
  logic [NUM_WR*ADDR_W-1:0] WrAddr;
  logic [NUM_WR*DATA_W-1:0] WrData;
  logic                     IssueEn;
  logic [ADDR_W-1:0]        IssueReg;
  logic                     ClearReq;
  logic                     Ready;

  modport master (
    output RdAddr, WrEn, WrAddr, WrData, IssueEn, IssueReg, ClearReq,
    input  RdData, RdBusy, Ready
  );

  modport slave (
    input  RdAddr, WrEn, WrAddr, WrData, IssueEn, IssueReg, ClearReq,
    output RdData, RdBusy, Ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, busy scoreboard and a
// sequential clear engine that zeroes the array after reset or on request.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];

  logic                idle;
  logic [ADDR_W-1:0]   wr_addr [NUM_WR];
  logic [DATA_W-1:0]   wr_data [NUM_WR];
  logic [NUM_WR-1:0]   wr_en;
  logic                issue_en;

  function automatic logic zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign idle      = (state_q == ST_IDLE);
  assign bus.Ready = idle;
  assign issue_en  = idle && bus.IssueEn && !zero_addr(bus.IssueReg);

  // Effective write enables: suppressed during a sweep and for hardwired zero.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_addr[j] = bus.WrAddr[j*ADDR_W +: ADDR_W];
    assign wr_data[j] = bus.WrData[j*DATA_W +: DATA_W];
    assign wr_en[j]   = bus.WrEn[j] && idle && !zero_addr(wr_addr[j]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_CLEAR) begin
      idx_d = idx_q + ADDR_W'(1);
      if (idx_q == ADDR_W'(NUM_REGS - 1)) state_d = ST_IDLE;
    end else if (bus.ClearReq) begin
      state_d = ST_CLEAR;
      idx_d   = '0;
    end
  end

  // Ascending port order makes the highest-index writer win on collisions.
  always_comb begin
    mem_d = mem_q;
    if (!idle) mem_d[idx_q] = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) mem_d[wr_addr[j]] = wr_data[j];
    end
  end

  // Issue is applied after write-clears so a new producer supersedes the old.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_d[wr_addr[j]] = 1'b0;
    end
    if (issue_en) busy_d[bus.IssueReg] = 1'b1;
    if (!idle) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Storage carries no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;

    assign ra = bus.RdAddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val = mem_q[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j] == ra)) rd_val = wr_data[j];
        end
      end
      if (zero_addr(ra) || !idle) rd_val = '0;
    end

    assign bus.RdData[i*DATA_W +: DATA_W] = rd_val;
    assign bus.RdBusy[i]                  = idle && busy_q[ra];
  end

endmodule
